// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and helpers for the SRAM slave.
//   htrans_t / hresp_t / hsize_t : bus field encodings
//   state_t                      : data-phase state machine states
//   byte_en()                    : little-endian lane enables for a transfer
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  // Wait counter is wide enough for 0..15 wait states.
  localparam int WAIT_CNT_WDT = 4;

  // Byte lanes touched by a transfer of the given size at the given byte
  // offset. Illegal sizes enable nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_en = 4'b1111;
      default:    byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB bus signals seen by the SRAM slave.
//   i_hsel/i_haddr/i_htrans/i_hwrite/i_hsize/i_hburst : address phase
//   i_hwdata                                          : write data (data phase)
//   i_hready                                          : bus-level HREADY
//   i_stall                                           : extra wait request
//   o_hrdata/o_hready/o_hresp                         : slave response
interface ahb_sram_slave_if #(
  parameter int DATA_WDT = 32
);
  logic                i_hsel;
  logic [31:0]         i_haddr;
  logic [1:0]          i_htrans;
  logic                i_hwrite;
  logic [2:0]          i_hsize;
  logic [2:0]          i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic                i_hready;
  logic                i_stall;
  logic [DATA_WDT-1:0] o_hrdata;
  logic                o_hready;
  logic [1:0]          o_hresp;

  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst,
    input  i_hwdata, i_hready, i_stall,
    output o_hrdata, o_hready, o_hresp
  );

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst,
    output i_hwdata, i_hready, i_stall,
    input  o_hrdata, o_hready, o_hresp
  );
endinterface

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: DEPTH x 32-bit word memory split into four byte lanes.
//   i_hclk  : clock
//   i_we    : per-lane write enable (bit n -> bits 8n+7:8n)
//   i_addr  : word address for both write and read
//   i_wdata : write data
//   o_rdata : combinational read data of i_addr
module ahb_sram_mem #(
  parameter int DATA_WDT = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_WDT = $clog2(DEPTH)
) (
  input  logic                i_hclk,
  input  logic [3:0]          i_we,
  input  logic [ADDR_WDT-1:0] i_addr,
  input  logic [DATA_WDT-1:0] i_wdata,
  output logic [DATA_WDT-1:0] o_rdata
);

  // One array per lane so each lane has a single writer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge i_hclk) begin
        if (i_we[gi]) begin
          lane_mem[i_addr] <= i_wdata[gi*8 +: 8];
        end
      end

      assign o_rdata[gi*8 +: 8] = lane_mem[i_addr];
    end
  endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave backed by an internal word-addressed SRAM.
//   i_hclk   : clock, all logic on the rising edge
//   i_hreset : synchronous active-high reset
//   bus      : AHB slave port (address/data phase inputs, stall, response)
// Legal transfers are served with WAIT_STATES fixed wait cycles plus any
// i_stall cycles; illegal transfers get a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset,
  ahb_sram_slave_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);

  state_t                  state_reg, state_next;
  logic [WAIT_CNT_WDT-1:0] wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0]           word_reg;
  logic [1:0]              lane_reg;
  logic [2:0]              size_reg;
  logic                    write_reg;

  logic          addr_req;
  logic          addr_phase;
  logic          addr_legal;
  logic          misaligned;
  logic          hready;
  hresp_t        hresp;
  logic          data_done;
  logic [3:0]    mem_we;
  logic [DATA_WDT-1:0] mem_rdata;

  // Burst type is not checked; it only travels with the transfer.
  logic unused_hburst;
  assign unused_hburst = ^bus.i_hburst;

  // A transfer request on the bus; it is only taken while we are ready,
  // so requests held during our own wait cycles are ignored.
  assign addr_req   = bus.i_hsel & bus.i_hready & bus.i_htrans[1];
  assign addr_phase = addr_req & hready;

  assign misaligned = ((bus.i_hsize == HSIZE_HALF) && bus.i_haddr[0]) ||
                      ((bus.i_hsize == HSIZE_WORD) && (bus.i_haddr[1:0] != 2'b00));
  assign addr_legal = (bus.i_hsize <= HSIZE_WORD) && !misaligned &&
                      ((bus.i_haddr >> 2) < 32'(DEPTH));

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      word_reg     <= '0;
      lane_reg     <= '0;
      size_reg     <= '0;
      write_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (addr_phase) begin
        word_reg  <= bus.i_haddr[AW+1:2];
        lane_reg  <= bus.i_haddr[1:0];
        size_reg  <= bus.i_hsize;
        write_reg <= bus.i_hwrite;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    hready        = 1'b1;
    hresp         = HRESP_OKAY;
    data_done     = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end
      ACCESS: begin
        // The fixed countdown runs regardless of stall; stall only holds
        // the phase open once the countdown has expired.
        if (wait_cnt_reg != '0) begin
          hready        = 1'b0;
          wait_cnt_next = wait_cnt_reg - WAIT_CNT_WDT'(1);
        end else if (bus.i_stall) begin
          hready = 1'b0;
        end else begin
          data_done  = 1'b1;
          state_next = IDLE;
        end
      end
      ERR1: begin
        hready     = 1'b0;
        hresp      = HRESP_ERROR;
        state_next = ERR2;
      end
      ERR2: begin
        hresp      = HRESP_ERROR;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A transfer taken in a ready cycle opens the next data phase.
    if (hready && addr_req) begin
      state_next    = addr_legal ? ACCESS : ERR1;
      wait_cnt_next = WAIT_CNT_WDT'(WAIT_STATES);
    end
  end

  // Writes land at the end of the completing cycle; a reset in that same
  // cycle drops them. hwdata is only looked at when a lane is enabled.
  assign mem_we = (data_done && write_reg && !i_hreset) ? byte_en(size_reg, lane_reg) : 4'b0000;

  ahb_sram_mem #(
    .DATA_WDT (DATA_WDT),
    .DEPTH    (DEPTH),
    .ADDR_WDT (AW)
  ) u_mem (
    .i_hclk  (i_hclk),
    .i_we    (mem_we),
    .i_addr  (word_reg),
    .i_wdata (bus.i_hwdata),
    .o_rdata (mem_rdata)
  );

  assign bus.o_hready = hready;
  assign bus.o_hresp  = hresp;
  assign bus.o_hrdata = (data_done && !write_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          lows;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset;
  logic        hsel_drv;
  logic [31:0] haddr_drv;
  logic [1:0]  htrans_drv;
  logic        hwrite_drv;
  logic [2:0]  hsize_drv;
  logic [2:0]  hburst_drv;
  logic [31:0] hwdata_drv;
  logic        stall_drv;
  logic [1:0]  active;
  logic        mon_en;

  logic        hready_a [3];
  logic [1:0]  hresp_a  [3];
  logic [31:0] hrdata_a [3];
  logic        mon_hready;
  logic [1:0]  mon_hresp;
  logic [31:0] mon_hrdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q [$];

  // Three slaves: WAIT_STATES 0, 2 and 3. Only the active one is selected.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ahb_sram_slave_if #(.DATA_WDT(32)) bus ();
    assign bus.i_hsel   = hsel_drv && (active == 2'(gi));
    assign bus.i_haddr  = haddr_drv;
    assign bus.i_htrans = htrans_drv;
    assign bus.i_hwrite = hwrite_drv;
    assign bus.i_hsize  = hsize_drv;
    assign bus.i_hburst = hburst_drv;
    assign bus.i_hwdata = hwdata_drv;
    assign bus.i_stall  = stall_drv && (active == 2'(gi));
    assign bus.i_hready = bus.o_hready;
    ahb_sram_slave #(
      .DATA_WDT    (32),
      .DEPTH       (1024),
      .WAIT_STATES ((gi == 0) ? 0 : (gi == 1) ? 2 : 3)
    ) u_dut (
      .i_hclk   (clk),
      .i_hreset (hreset),
      .bus      (bus)
    );
    assign hready_a[gi] = bus.o_hready;
    assign hresp_a[gi]  = bus.o_hresp;
    assign hrdata_a[gi] = bus.o_hrdata;
  end

  always_comb begin
    mon_hready = hready_a[0];
    mon_hresp  = hresp_a[0];
    mon_hrdata = hrdata_a[0];
    case (active)
      2'd1: begin mon_hready = hready_a[1]; mon_hresp = hresp_a[1]; mon_hrdata = hrdata_a[1]; end
      2'd2: begin mon_hready = hready_a[2]; mon_hresp = hresp_a[2]; mon_hrdata = hrdata_a[2]; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One address phase. Returns one tick after the edge that accepted it,
  // i.e. at the start of its data phase, with hwdata set for that phase.
  task automatic beat(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic err,
                      input logic [31:0] rdata, input int lows, input string tag);
    int n = 0;
    htrans_drv = trans;
    haddr_drv  = addr;
    hwrite_drv = wr;
    hsize_drv  = size;
    if (trans[1] && hsel_drv && lows >= 0)
      exp_q.push_back('{wr, err, rdata, lows, tag});
    do begin
      @(negedge clk);
      n++;
    end while (!mon_hready && n < 64);
    if (!mon_hready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: hready stuck low, got %0d expected 1", tag, mon_hready);
    end
    @(posedge clk);
    #1;
    hwdata_drv = (wr && trans[1] && hsel_drv) ? wdata : 32'hxxxxxxxx;
    htrans_drv = HTRANS_IDLE;
  endtask

  task automatic idle_beat();
    beat(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0, -1, "idle");
  endtask

  // Stall in the third data-phase cycle, after a 2-cycle countdown expires.
  task automatic stall_third_cycle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall_drv = 1'b1;
    @(posedge clk); #1;
    stall_drv = 1'b0;
  endtask

  // Monitor: follows data phases on the active slave and scores them.
  initial begin : monitor
    bit     in_phase;
    int     lows;
    logic   low_bad;
    logic [1:0] head_resp;
    exp_t   e;
    in_phase = 0;
    lows     = 0;
    low_bad  = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (hreset) begin
        in_phase = 0;
        continue;
      end
      if (in_phase) begin
        head_resp = (exp_q.size() > 0 && exp_q[0].err) ? HRESP_ERROR : HRESP_OKAY;
        if (!mon_hready) begin
          lows++;
          if (mon_hresp !== head_resp || mon_hrdata !== 32'h0) low_bad = 1'b1;
        end else begin
          in_phase = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_phase: got resp %0d with no expected transfer", mon_hresp);
          end else begin
            e = exp_q.pop_front();
            check({e.tag, "_resp"}, 64'(mon_hresp), e.err ? 64'(HRESP_ERROR) : 64'(HRESP_OKAY));
            check({e.tag, "_waits"}, 64'(lows), 64'(e.lows));
            check({e.tag, "_rdata"}, 64'(mon_hrdata), (e.wr || e.err) ? 64'h0 : 64'(e.rdata));
            check({e.tag, "_waitcyc"}, 64'(low_bad), 64'h0);
            $display("[TB] %s: resp=%0d waits=%0d rdata=0x%08h", e.tag, mon_hresp, lows, mon_hrdata);
          end
        end
      end else begin
        check("zero_wait_okay", {29'h0, mon_hready, mon_hresp, mon_hrdata}, {29'h0, 1'b1, 2'b00, 32'h0});
      end
      if (mon_hready && hsel_drv && htrans_drv[1]) begin
        in_phase = 1;
        lows     = 0;
        low_bad  = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    hreset     = 1'b1;
    hsel_drv   = 1'b1;
    haddr_drv  = 32'h0;
    htrans_drv = HTRANS_IDLE;
    hwrite_drv = 1'b0;
    hsize_drv  = HSIZE_WORD;
    hburst_drv = 3'b000;
    hwdata_drv = 32'h0;
    stall_drv  = 1'b0;
    active     = 2'd0;
    mon_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    hreset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_hready", 64'(hready_a[k]), 64'h1);
      check("reset_hresp",  64'(hresp_a[k]),  64'h0);
      check("reset_hrdata", 64'(hrdata_a[k]), 64'h0);
    end
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // 1: write then read back-to-back, zero waits.
    beat(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hA5A5A5A5, 1'b0, 32'h0, 0, "t1_wr");
    beat(HTRANS_SEQ,    32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'hA5A5A5A5, 0, "t1_rd");
    idle_beat();

    // 2: byte lanes then a halfword, junk on unused lanes.
    beat(HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_BYTE, 32'hEEEEEE11, 1'b0, 32'h0, 0, "t2_b0");
    beat(HTRANS_NONSEQ, 32'h21, 1'b1, HSIZE_BYTE, 32'hEEEE22EE, 1'b0, 32'h0, 0, "t2_b1");
    beat(HTRANS_NONSEQ, 32'h22, 1'b1, HSIZE_BYTE, 32'hEE33EEEE, 1'b0, 32'h0, 0, "t2_b2");
    beat(HTRANS_NONSEQ, 32'h23, 1'b1, HSIZE_BYTE, 32'h44EEEEEE, 1'b0, 32'h0, 0, "t2_b3");
    beat(HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h44332211, 0, "t2_rd1");
    beat(HTRANS_NONSEQ, 32'h22, 1'b1, HSIZE_HALF, 32'hBEEFEEEE, 1'b0, 32'h0, 0, "t2_h");
    beat(HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'hBEEF2211, 0, "t2_rd2");
    idle_beat();

    // 4: illegal accesses, deselected transfer, then legal reads.
    beat(HTRANS_NONSEQ, 32'h0,    1'b1, HSIZE_WORD, 32'h0BADF00D, 1'b0, 32'h0, 0, "t4_wr");
    beat(HTRANS_NONSEQ, 32'h1000, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'h0, 1, "t4_oob");
    beat(HTRANS_NONSEQ, 32'h1,    1'b1, HSIZE_HALF, 32'hFFFFFFFF, 1'b1, 32'h0, 1, "t4_misal");
    beat(HTRANS_NONSEQ, 32'h8,    1'b0, 3'b011,     32'h0, 1'b1, 32'h0, 1, "t4_size");
    beat(HTRANS_NONSEQ, 32'h0,    1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0BADF00D, 0, "t4_rd0");
    hsel_drv = 1'b0;
    beat(HTRANS_NONSEQ, 32'h10,   1'b1, HSIZE_WORD, 32'hFFFFFFFF, 1'b0, 32'h0, 0, "t4_nosel");
    hsel_drv = 1'b1;
    beat(HTRANS_NONSEQ, 32'h10,   1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'hA5A5A5A5, 0, "t4_rd10");
    idle_beat();

    // 5: 16-beat INCR write with BUSY after every even beat, then readback.
    hburst_drv = 3'b001;
    for (int i = 0; i < 16; i++) begin
      beat((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h100 + 32'(i) * 4, 1'b1, HSIZE_WORD,
           32'hC0DE0000 + 32'(i) * 32'h101, 1'b0, 32'h0, 0, $sformatf("t5_wr%0d", i));
      if (i < 15 && (i % 2) == 0)
        beat(HTRANS_BUSY, 32'h100 + 32'(i + 1) * 4, 1'b1, HSIZE_WORD, 32'h0, 1'b0, 32'h0, -1, "t5_busy");
    end
    for (int i = 0; i < 16; i++) begin
      beat((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h100 + 32'(i) * 4, 1'b0, HSIZE_WORD,
           32'h0, 1'b0, 32'hC0DE0000 + 32'(i) * 32'h101, 0, $sformatf("t5_rd%0d", i));
    end
    hburst_drv = 3'b000;
    idle_beat();

    // 3: two fixed waits plus a one-cycle stall.
    active = 2'd1;
    beat(HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD, 32'h5A5A1234, 1'b0, 32'h0, 3, "t3_wr");
    stall_third_cycle();
    idle_beat();
    beat(HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h5A5A1234, 3, "t3_rd_stall");
    stall_third_cycle();
    idle_beat();
    beat(HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h5A5A1234, 2, "t3_rd");
    idle_beat();

    // 6: reset in the middle of a waited write drops it.
    active = 2'd2;
    beat(HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD, 32'h12345678, 1'b0, 32'h0, 3, "t6_wr_old");
    idle_beat();
    beat(HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 1'b0, 32'h0, -1, "t6_wr_new");
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    check("t6_rst_hready", 64'(mon_hready), 64'h1);
    check("t6_rst_hresp",  64'(mon_hresp),  64'h0);
    check("t6_rst_hrdata", 64'(mon_hrdata), 64'h0);
    @(posedge clk); #1;
    beat(HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h12345678, 3, "t6_rd");
    idle_beat();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
